// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, waits for lock, qualifies it as stable, then
// releases core_rst. Retries on timeout, re-runs on lock loss or on a restart request.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 742500,
    parameter int STABLE_CYCLES = 4096,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 24
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fail,
    output logic       restart_ack,
    output logic [7:0] relock_count
);

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAILED
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [7:0]         relock_next;
    logic               ack_next;
    logic [1:0]         sync_reg;
    logic               lock_s;

    // pll_locked is asynchronous to refclk; nothing but lock_s may feed decisions.
    assign lock_s = sync_reg[1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg    <= RESET_PLL;
            cnt_reg      <= '0;
            retry_reg    <= '0;
            sync_reg     <= '0;
            pll_rst      <= 1'b1;
            core_rst     <= 1'b1;
            ready        <= 1'b0;
            fail         <= 1'b0;
            restart_ack  <= 1'b0;
            relock_count <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            retry_reg    <= retry_next;
            sync_reg     <= {sync_reg[0], pll_locked};
            pll_rst      <= (state_next == RESET_PLL) || (state_next == FAILED);
            core_rst     <= (state_next != RUN);
            ready        <= (state_next == RUN);
            fail         <= (state_next == FAILED);
            restart_ack  <= ack_next;
            relock_count <= relock_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CNT_W'(1);
        retry_next  = retry_reg;
        relock_next = relock_count;
        ack_next    = 1'b0;

        case (state_reg)
            RESET_PLL: begin
                if (cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock is checked before the timeout so a late lock is never discarded.
                if (lock_s) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_next = '0;
                    if (retry_reg == RETRY_W'(MAX_RETRIES)) begin
                        state_next = FAILED;
                    end else begin
                        retry_next = retry_reg + RETRY_W'(1);
                        state_next = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                    retry_next = '0;
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!lock_s) begin
                    state_next = RESET_PLL;
                    if (relock_count != 8'hFF) begin
                        relock_next = relock_count + 8'd1;
                    end
                end
            end
            FAILED: begin
                cnt_next = '0;
            end
            default: begin
                state_next = RESET_PLL;
                cnt_next   = '0;
            end
        endcase

        // A restart overrides everything, including a lock loss counted in RUN.
        if (restart_req) begin
            state_next  = RESET_PLL;
            cnt_next    = '0;
            retry_next  = '0;
            relock_next = relock_count;
            ack_next    = 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: stimulus queues the expected output vector and the cycle of
// each output change; a negedge monitor pops and compares whenever the outputs change.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst, core_rst, ready, fail, restart_ack;
    logic [7:0] relock_count;

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .CNT_W        (24)
    ) dut (
        .refclk      (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .core_rst    (core_rst),
        .ready       (ready),
        .fail        (fail),
        .restart_ack (restart_ack),
        .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [12:0] v;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        mon_en = 1'b0;
    logic [12:0] prev_v;
    logic [12:0] cur_v;
    logic [12:0] ev_last;
    exp_t        e_mon;

    // Vector layout: {pll_rst, core_rst, ready, fail, restart_ack, relock_count}
    function automatic logic [12:0] mk(input logic pr, input logic cr, input logic rd,
                                       input logic fl, input logic ak, input logic [7:0] rc);
        return {pr, cr, rd, fl, ak, rc};
    endfunction

    localparam logic [12:0] RST_V = {5'b11000, 8'd0};

    always @(posedge clk) cyc = cyc + 1;

    assign cur_v = {pll_rst, core_rst, ready, fail, restart_ack, relock_count};

    always @(negedge clk) begin
        if (mon_en && (cur_v !== prev_v)) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_change cyc=%0d got=%h required no change from %h",
                         cyc, cur_v, prev_v);
            end else begin
                e_mon = exp_q.pop_front();
                if (e_mon.c != cyc || e_mon.v !== cur_v) begin
                    bad = bad + 1;
                    $display("FAIL event cyc=%0d got=%h required cyc=%0d value=%h",
                             cyc, cur_v, e_mon.c, e_mon.v);
                end else begin
                    $display("event cyc=%0d outs=%h ok", cyc, cur_v);
                end
            end
            prev_v = cur_v;
        end
    end

    task automatic to_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic expect_at(input int c, input logic [12:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        exp_q.push_back(e);
        ev_last = v;
    endtask

    task automatic settle(input int t, input string name);
        to_cyc(t);
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL %s_pending got=%0d events outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            $display("%s all events seen", name);
        end
    endtask

    task automatic do_reset(input logic lock_v, output int r);
        if (ev_last !== RST_V) expect_at(cyc, RST_V);
        rst         = 1'b1;
        restart_req = 1'b0;
        pll_locked  = lock_v;
        to_cyc(cyc + 3);
        rst = 1'b0;
        r   = cyc;
    endtask

    initial begin
        int r;
        int d;
        int rc_m;

        ev_last = RST_V;
        repeat (3) @(posedge clk);
        #1;
        prev_v = RST_V;
        mon_en = 1'b1;
        total  = total + 1;
        if (cur_v !== RST_V) begin
            bad = bad + 1;
            $display("FAIL reset_state got=%h required %h", cur_v, RST_V);
        end else begin
            $display("reset_state outs=%h ok", cur_v);
        end

        // Clean bring-up with lock always present.
        pll_locked = 1'b1;
        to_cyc(cyc + 1);
        rst = 1'b0;
        r   = cyc;
        expect_at(r + 4,  mk(0, 1, 0, 0, 0, 8'd0));
        expect_at(r + 13, mk(0, 0, 1, 0, 0, 8'd0));
        settle(r + 16, "bringup");

        // Restart request coincident with a lock loss in RUN.
        d = cyc + 1;
        to_cyc(d);
        pll_locked = 1'b0;
        expect_at(d + 3,  mk(1, 1, 0, 0, 1, 8'd0));
        expect_at(d + 4,  mk(1, 1, 0, 0, 0, 8'd0));
        expect_at(d + 7,  mk(0, 1, 0, 0, 0, 8'd0));
        expect_at(d + 16, mk(0, 0, 1, 0, 0, 8'd0));
        to_cyc(d + 1);
        pll_locked = 1'b1;
        to_cyc(d + 2);
        restart_req = 1'b1;
        to_cyc(d + 3);
        restart_req = 1'b0;
        settle(d + 18, "restart_vs_lockloss");

        // Repeated one-cycle lock drops in RUN; relock_count saturates.
        rc_m = 0;
        for (int i = 0; i < 300; i++) begin
            d = cyc + 1;
            to_cyc(d);
            pll_locked = 1'b0;
            rc_m = (rc_m == 255) ? 255 : rc_m + 1;
            expect_at(d + 3,  mk(1, 1, 0, 0, 0, 8'(rc_m)));
            expect_at(d + 7,  mk(0, 1, 0, 0, 0, 8'(rc_m)));
            expect_at(d + 16, mk(0, 0, 1, 0, 0, 8'(rc_m)));
            to_cyc(d + 1);
            pll_locked = 1'b1;
            to_cyc(d + 17);
        end
        settle(cyc + 2, "relock_loop");
        total = total + 1;
        if (relock_count !== 8'd255) begin
            bad = bad + 1;
            $display("FAIL relock_saturate got=%0d required 255", relock_count);
        end else begin
            $display("relock_saturate count=%0d ok", relock_count);
        end

        // Glitch during lock qualification at cnt=5: requalify from scratch.
        do_reset(1'b1, r);
        expect_at(r + 4,  mk(0, 1, 0, 0, 0, 8'd0));
        expect_at(r + 20, mk(0, 0, 1, 0, 0, 8'd0));
        to_cyc(r + 8);
        pll_locked = 1'b0;
        to_cyc(r + 9);
        pll_locked = 1'b1;
        settle(r + 23, "stable_glitch");

        // No lock: three attempts, then FAIL; restart pulse recovers.
        do_reset(1'b0, r);
        expect_at(r + 4,   mk(0, 1, 0, 0, 0, 8'd0));
        expect_at(r + 36,  mk(1, 1, 0, 0, 0, 8'd0));
        expect_at(r + 40,  mk(0, 1, 0, 0, 0, 8'd0));
        expect_at(r + 72,  mk(1, 1, 0, 0, 0, 8'd0));
        expect_at(r + 76,  mk(0, 1, 0, 0, 0, 8'd0));
        expect_at(r + 108, mk(1, 1, 0, 1, 0, 8'd0));
        expect_at(r + 113, mk(1, 1, 0, 0, 1, 8'd0));
        expect_at(r + 114, mk(1, 1, 0, 0, 0, 8'd0));
        expect_at(r + 117, mk(0, 1, 0, 0, 0, 8'd0));
        to_cyc(r + 112);
        restart_req = 1'b1;
        to_cyc(r + 113);
        restart_req = 1'b0;
        settle(r + 120, "timeout_fail");

        // Asynchronous reset in WAIT_LOCK at cnt=20.
        do_reset(1'b0, r);
        expect_at(r + 4, mk(0, 1, 0, 0, 0, 8'd0));
        to_cyc(r + 24);
        expect_at(cyc, RST_V);
        rst = 1'b1;
        #1;
        total = total + 1;
        if (cur_v !== RST_V) begin
            bad = bad + 1;
            $display("FAIL async_reset got=%h required %h", cur_v, RST_V);
        end else begin
            $display("async_reset outs=%h ok", cur_v);
        end
        to_cyc(cyc + 3);
        pll_locked = 1'b1;
        to_cyc(cyc + 1);
        rst = 1'b0;
        r   = cyc;
        expect_at(r + 4,  mk(0, 1, 0, 0, 0, 8'd0));
        expect_at(r + 13, mk(0, 0, 1, 0, 0, 8'd0));
        settle(r + 16, "after_async_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
